// File: rtl/rf_access_arbiter_if.sv
// rf_access_arbiter_if
//   Requester-side bus of the register-file access arbiter.
//   Carries one packed request lane per requester, the per-requester response handshake,
//   and the shared response data.
//   master : requesters (drive req_valid/req_write/req_addr_*/req_data_w and rsp_ready)
//   slave  : arbiter    (drives req_ready, rsp_valid, rsp_data_r1/r2)
//   Lane i of every packed bus sits at [i*W +: W].
interface rf_access_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_r1;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_r2;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_w;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_w;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data_r1;
  logic [DATA_WIDTH-1:0]         rsp_data_r2;

  modport master (
    output req_valid, req_write, req_addr_r1, req_addr_r2, req_addr_w, req_data_w, rsp_ready,
    input  req_ready, rsp_valid, rsp_data_r1, rsp_data_r2
  );

  modport slave (
    input  req_valid, req_write, req_addr_r1, req_addr_r2, req_addr_w, req_data_w, rsp_ready,
    output req_ready, rsp_valid, rsp_data_r1, rsp_data_r2
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//   Round-robin sequencer sharing one dual-read/single-write register file among NUM_REQ
//   requesters. One operation is outstanding at a time: IDLE -> RD_OP|WR_OP -> RESP -> IDLE.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     bus (slave)       requester request/response channels (rf_access_arbiter_if)
//     rf_read/rf_write  RF strobes, never both high, each high only during its op cycle
//     rf_addr_*/rf_data_w  latched operands of the current operation
//     rf_data_r1/r2     RF read data, captured at the end of the read cycle
//     busy              high whenever the sequencer is not idle
module rf_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_access_arbiter_if.slave    bus,
  output logic                  rf_read,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_addr_r1,
  output logic [ADDR_WIDTH-1:0] rf_addr_r2,
  output logic [ADDR_WIDTH-1:0] rf_addr_w,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  input  logic [DATA_WIDTH-1:0] rf_data_r1,
  input  logic [DATA_WIDTH-1:0] rf_data_r2,
  output logic                  busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RD_OP, WR_OP, RESP} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_r1_q, addr_r1_d;
  logic [ADDR_WIDTH-1:0]   addr_r2_q, addr_r2_d;
  logic [ADDR_WIDTH-1:0]   addr_w_q, addr_w_d;
  logic [DATA_WIDTH-1:0]   data_w_q, data_w_d;
  logic [DATA_WIDTH-1:0]   rsp_data_r1_q, rsp_data_r1_d;
  logic [DATA_WIDTH-1:0]   rsp_data_r2_q, rsp_data_r2_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic                    rf_read_q, rf_read_d;
  logic                    rf_write_q, rf_write_d;

  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      gnt_onehot;
  logic                    found;
  logic [IDX_W-1:0]        grant;
  logic [IDX_W-1:0]        cand;

  // Per-requester views of the packed request lanes.
  logic [ADDR_WIDTH-1:0]   req_a1 [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   req_a2 [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   req_aw [NUM_REQ];
  logic [DATA_WIDTH-1:0]   req_dw [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_a1[gi] = bus.req_addr_r1[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_a2[gi] = bus.req_addr_r2[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_aw[gi] = bus.req_addr_w[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_dw[gi] = bus.req_data_w[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin search starting at ptr_q; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    addr_r1_d     = addr_r1_q;
    addr_r2_d     = addr_r2_q;
    addr_w_d      = addr_w_q;
    data_w_d      = data_w_q;
    rsp_data_r1_d = rsp_data_r1_q;
    rsp_data_r2_d = rsp_data_r2_q;
    rsp_valid_d   = rsp_valid_q;
    rf_read_d     = 1'b0;   // strobes live for exactly the one op cycle
    rf_write_d    = 1'b0;
    req_ready     = '0;
    gnt_onehot    = '0;
    gnt_onehot[gnt_q] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[grant] = 1'b1;
          gnt_d     = grant;
          addr_r1_d = req_a1[grant];
          addr_r2_d = req_a2[grant];
          addr_w_d  = req_aw[grant];
          data_w_d  = req_dw[grant];
          if (bus.req_write[grant]) begin
            state_d = WR_OP;
            // A protected r0 write still spends its op cycle, just without the strobe.
            rf_write_d = !(PROTECT_R0 && (req_aw[grant] == '0));
          end else begin
            state_d   = RD_OP;
            rf_read_d = 1'b1;
          end
        end
      end
      RD_OP: begin
        rsp_data_r1_d = rf_data_r1;
        rsp_data_r2_d = rf_data_r2;
        rsp_valid_d   = gnt_onehot;
        state_d       = RESP;
      end
      WR_OP: begin
        rsp_valid_d = gnt_onehot;
        state_d     = RESP;
      end
      RESP: begin
        if (|(bus.rsp_ready & rsp_valid_q)) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
          ptr_d       = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      addr_r1_q     <= '0;
      addr_r2_q     <= '0;
      addr_w_q      <= '0;
      data_w_q      <= '0;
      rsp_data_r1_q <= '0;
      rsp_data_r2_q <= '0;
      rsp_valid_q   <= '0;
      rf_read_q     <= 1'b0;
      rf_write_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      addr_r1_q     <= addr_r1_d;
      addr_r2_q     <= addr_r2_d;
      addr_w_q      <= addr_w_d;
      data_w_q      <= data_w_d;
      rsp_data_r1_q <= rsp_data_r1_d;
      rsp_data_r2_q <= rsp_data_r2_d;
      rsp_valid_q   <= rsp_valid_d;
      rf_read_q     <= rf_read_d;
      rf_write_q    <= rf_write_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data_r1 = rsp_data_r1_q;
  assign bus.rsp_data_r2 = rsp_data_r2_q;
  assign rf_read         = rf_read_q;
  assign rf_write        = rf_write_q;
  assign rf_addr_r1      = addr_r1_q;
  assign rf_addr_r2      = addr_r2_q;
  assign rf_addr_w       = addr_w_q;
  assign rf_data_w       = data_w_q;
  assign busy            = (state_q != IDLE);
endmodule
